// File: rtl/sram_capture_ctrl_if.sv
// Sample capture, readout stream and SRAM port bundle for sram_capture_ctrl.
// The master modport is the controller side; slave is the environment (sampler, host, SRAM).
`timescale 1ns/1ps
interface sram_capture_ctrl_if;
  logic        start;
  logic        dump;
  logic [15:0] len_m1;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        cap_done;
  logic        sram_wen;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;

  modport master (
    input  start, dump, len_m1, sample_valid, sample_data, out_ready, sram_rdata,
    output out_valid, out_data, out_last, busy, cap_done, sram_wen, sram_addr, sram_wdata
  );

  modport slave (
    output start, dump, len_m1, sample_valid, sample_data, out_ready, sram_rdata,
    input  out_valid, out_data, out_last, busy, cap_done, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_capture_ctrl.sv
// Captures a block of samples into a 64Kx16 SPRAM from address 0 and streams it back
// over valid/ready. Every output is a register with an asynchronous active-high reset.
//
// state    | meaning
// IDLE     | waiting for start (capture) or dump (readout)
// CAP      | writing accepted samples; fin_q marks the final write cycle
// RD_ADDR  | sram_addr driven with the current word address
// RD_LATCH | address held while the bank-muxed read data settles; data latched
// RD_OUT   | word presented on out_data until the consumer takes it
`timescale 1ns/1ps
module sram_capture_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  sram_capture_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAP      = 3'd1,
    RD_ADDR  = 3'd2,
    RD_LATCH = 3'd3,
    RD_OUT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] out_data_q, out_data_d;
  logic        wen_q, wen_d;
  logic        fin_q, fin_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        cap_done_q, cap_done_d;
  logic        busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_data_q  <= '0;
      wen_q       <= 1'b0;
      fin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cap_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_data_q  <= out_data_d;
      wen_q       <= wen_d;
      fin_q       <= fin_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cap_done_q  <= cap_done_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_data_d  = out_data_q;
    wen_d       = 1'b0;
    fin_d       = fin_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cap_done_d  = cap_done_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d      = bus.len_m1;
          ptr_d      = '0;
          cnt_d      = '0;
          fin_d      = 1'b0;
          cap_done_d = 1'b0;
          state_d    = CAP;
        end else if (bus.dump) begin
          len_d   = bus.len_m1;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = RD_ADDR;
        end
      end
      CAP: begin
        // Final write is on the bus this cycle; samples arriving now are beyond the block.
        if (fin_q) begin
          fin_d      = 1'b0;
          cap_done_d = 1'b1;
          state_d    = IDLE;
        end else if (bus.sample_valid) begin
          wen_d   = 1'b1;
          addr_d  = ptr_q;
          wdata_d = bus.sample_data;
          ptr_d   = ptr_q + 16'd1;
          cnt_d   = cnt_q + 16'd1;
          if (cnt_q == len_q) fin_d = 1'b1;
        end
      end
      RD_ADDR: begin
        state_d = RD_LATCH;
      end
      RD_LATCH: begin
        out_data_d  = bus.sram_rdata;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_q == len_q);
        state_d     = RD_OUT;
      end
      RD_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 16'd1;
            cnt_d   = cnt_q + 16'd1;
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sram_wen   = wen_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = busy_q;
  assign bus.cap_done   = cap_done_q;

endmodule

// File: tb/tb_sram_capture_ctrl.sv
// Directed bench for sram_capture_ctrl with a behavioural 64Kx16 SRAM (sync write, async read).
`timescale 1ns/1ps
module tb_sram_capture_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sram_capture_ctrl_if bus ();

  sram_capture_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:65535];
  always @(posedge clk) if (bus.sram_wen) mem[bus.sram_addr] <= bus.sram_wdata;
  assign bus.sram_rdata = mem[bus.sram_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".out_data"},  bus.out_data,  0);
    chk({tag, ".out_last"},  bus.out_last,  0);
    chk({tag, ".busy"},      bus.busy,      0);
    chk({tag, ".cap_done"},  bus.cap_done,  0);
    chk({tag, ".sram_wen"},  bus.sram_wen,  0);
    chk({tag, ".sram_addr"}, bus.sram_addr, 0);
    chk({tag, ".sram_wdata"},bus.sram_wdata,0);
  endtask

  logic [15:0] pat [4];
  int n;
  bit aborted;

  initial begin
    checks = 0;
    errors = 0;
    pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;
    rst = 1'b0;
    bus.start = 0; bus.dump = 0; bus.len_m1 = 0;
    bus.sample_valid = 0; bus.sample_data = 0; bus.out_ready = 0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    tick(); tick();
    #3 rst = 1'b0;
    tick();

    // Capture with gaps; start and dump together -> start wins
    bus.len_m1 = 16'd3; bus.start = 1; bus.dump = 1;
    tick();
    bus.start = 0; bus.dump = 0;
    chk("cap.busy", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin
      bus.sample_valid = 1; bus.sample_data = pat[i];
      tick();
      bus.sample_valid = 0;
      chk("cap.wen", bus.sram_wen, 1);
      chk("cap.addr", bus.sram_addr, i);
      chk("cap.wdata", bus.sram_wdata, pat[i]);
      chk("cap.cap_done_early", bus.cap_done, 0);
      chk("cap.no_readout", bus.out_valid, 0);
      tick();
      chk("cap.wen_single", bus.sram_wen, 0);
      if (i == 3) begin
        chk("cap.cap_done", bus.cap_done, 1);
        chk("cap.busy_end", bus.busy, 0);
      end else begin
        chk("cap.busy_mid", bus.busy, 1);
        tick();
      end
    end

    // Dump, consumer always ready
    bus.out_ready = 1; bus.len_m1 = 16'd3; bus.dump = 1;
    tick();
    bus.dump = 0;
    chk("dmp.addr0", bus.sram_addr, 0);
    chk("dmp.valid_addr", bus.out_valid, 0);
    tick();
    chk("dmp.valid_latch", bus.out_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("dmp.valid", bus.out_valid, 1);
      chk("dmp.data", bus.out_data, pat[i]);
      chk("dmp.last", bus.out_last, (i == 3));
      tick();
      chk("dmp.valid_drop", bus.out_valid, 0);
      if (i != 3) begin
        chk("dmp.addr_next", bus.sram_addr, i + 1);
        tick();
        chk("dmp.addr_hold", bus.sram_addr, i + 1);
        tick();
      end else begin
        chk("dmp.busy_end", bus.busy, 0);
      end
    end

    // Backpressure on the second word
    bus.dump = 1;
    tick();
    bus.dump = 0;
    tick(); tick();
    chk("bp.data0", bus.out_data, 16'h1111);
    tick();
    bus.out_ready = 0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp.valid_hold", bus.out_valid, 1);
      chk("bp.data_hold", bus.out_data, 16'h2222);
      chk("bp.addr_hold", bus.sram_addr, 1);
      chk("bp.last_hold", bus.out_last, 0);
      tick();
    end
    bus.out_ready = 1;
    tick();
    chk("bp.resume_valid", bus.out_valid, 0);
    chk("bp.resume_addr", bus.sram_addr, 2);
    tick(); tick();
    chk("bp.data2", bus.out_data, 16'h3333);
    chk("bp.last2", bus.out_last, 0);
    tick(); tick(); tick();
    chk("bp.data3", bus.out_data, 16'h4444);
    chk("bp.last3", bus.out_last, 1);
    tick();
    chk("bp.busy_end", bus.busy, 0);

    // Ramp capture across the bank boundary with ignored start/dump pulses
    bus.len_m1 = 16'd16385; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i <= 16385; i++) begin
      bus.sample_valid = 1; bus.sample_data = i[15:0];
      if (i == 100) begin
        bus.start = 1; bus.dump = 1; bus.len_m1 = 16'd5;
      end
      tick();
      bus.start = 0; bus.dump = 0;
      if (i == 100 || i == 16383 || i == 16384 || i == 16385) begin
        chk("ramp.wen", bus.sram_wen, 1);
        chk("ramp.addr", bus.sram_addr, i);
        chk("ramp.wdata", bus.sram_wdata, i);
      end
      if (i == 16000) begin
        chk("ramp.busy", bus.busy, 1);
        chk("ramp.cap_done_early", bus.cap_done, 0);
      end
    end
    bus.sample_valid = 0;
    tick();
    chk("ramp.cap_done", bus.cap_done, 1);
    chk("ramp.busy_end", bus.busy, 0);
    chk("ramp.wen_end", bus.sram_wen, 0);

    // Dump the ramp back
    bus.len_m1 = 16'd16385; bus.out_ready = 1; bus.dump = 1;
    tick();
    bus.dump = 0;
    aborted = 0;
    for (int i = 0; i <= 16385; i++) begin
      n = 0;
      while (!bus.out_valid && n < 4) begin
        chk("rramp.addr_pre", bus.sram_addr, i);
        tick();
        n++;
      end
      if (!bus.out_valid) begin
        chk("rramp.timeout", bus.out_valid, 1);
        aborted = 1;
        break;
      end
      chk("rramp.addr", bus.sram_addr, i);
      chk("rramp.data", bus.out_data, i);
      chk("rramp.last", bus.out_last, (i == 16385));
      tick();
    end
    if (!aborted) begin
      chk("rramp.busy_end", bus.busy, 0);
      chk("rramp.valid_end", bus.out_valid, 0);
    end

    // Reset in RD_OUT, then a fresh dump restarts at address 0
    bus.len_m1 = 16'd3; bus.out_ready = 1; bus.dump = 1;
    tick();
    bus.dump = 0;
    tick(); tick();
    chk("rmid.data0", bus.out_data, 16'h0000);
    tick();
    bus.out_ready = 0;
    tick(); tick();
    chk("rmid.valid_before", bus.out_valid, 1);
    chk("rmid.addr_before", bus.sram_addr, 1);
    chk("rmid.data_before", bus.out_data, 16'h0001);
    #3 rst = 1'b1;
    #1 chk_all_zero("rmid.reset");
    #2 rst = 1'b0;
    tick();
    bus.out_ready = 1; bus.dump = 1;
    tick();
    bus.dump = 0;
    chk("rmid.restart_addr", bus.sram_addr, 0);
    tick(); tick();
    chk("rmid.restart_valid", bus.out_valid, 1);
    chk("rmid.restart_data", bus.out_data, 16'h0000);
    chk("rmid.restart_addr_out", bus.sram_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
